// File: rtl/data_cache_sa_pkg.sv
// data_cache_sa_pkg: FSM encoding and field-width helpers shared by the cache and its LRU.
package data_cache_sa_pkg;
  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;
  localparam int FLAG_FIXED_W = 2;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int tag_w(input int sets, input int words);
    return 30 - $clog2(sets) - $clog2(words);
  endfunction
endpackage

// File: rtl/data_cache_sa_lru.sv
// data_cache_sa_lru: per-set true-LRU ages; age 0 is MRU, age WAYS-1 is the replacement victim.
module data_cache_sa_lru import data_cache_sa_pkg::*; #(
  parameter int WAYS = 2,
  parameter int SETS = 4,
  localparam int WW = idx_w(WAYS),
  localparam int SW = idx_w(SETS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          touch_i,
  input  logic [SW-1:0] set_i,
  input  logic [WW-1:0] way_i,
  input  logic [SW-1:0] dbg_set_i,
  input  logic [WW-1:0] dbg_way_i,
  output logic [WW-1:0] victim_o,
  output logic [WW-1:0] dbg_age_o
);
  logic [WW-1:0] age_q [SETS][WAYS];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WW'(w);
    end else if (touch_i) begin
      for (int w = 0; w < WAYS; w++)
        if (WW'(w) == way_i) age_q[set_i][w] <= '0;
        else if (age_q[set_i][w] < age_q[set_i][way_i]) age_q[set_i][w] <= age_q[set_i][w] + WW'(1);
    end
  always_comb begin
    victim_o = '0;
    for (int w = 0; w < WAYS; w++)
      if (age_q[set_i][w] == WW'(WAYS - 1)) victim_o = WW'(w);
  end
  assign dbg_age_o = age_q[dbg_set_i][dbg_way_i];
endmodule

// File: rtl/data_cache_sa.sv
// data_cache_sa: set-associative write-back/write-allocate data cache with word-serial
// req/ack refill and write-back, true-LRU replacement and a read-only debug port.
module data_cache_sa import data_cache_sa_pkg::*; #(
  parameter int WAYS  = 2,
  parameter int SETS  = 4,
  parameter int WORDS = 8,
  localparam int WW = idx_w(WAYS),
  localparam int SW = idx_w(SETS),
  localparam int OW = idx_w(WORDS),
  localparam int TW = tag_w(SETS, WORDS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      r0w1,
  input  logic [31:0]               addr,
  input  logic [31:0]               din,
  output logic [31:0]               dout,
  output logic                      rdy,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [31:0]               mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata,
  input  logic                      mem_ack,
  input  logic [SW-1:0]             dbg_set,
  input  logic [WW-1:0]             dbg_way,
  output logic [32*WORDS-1:0]       dbg_line,
  output logic [FLAG_FIXED_W+WW-1:0] dbg_flags
);
  state_t          state_q, state_d;
  logic [31:0]     data_q [WAYS][SETS][WORDS];
  logic [TW-1:0]   tag_q [WAYS][SETS];
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [29:0]     addr_q, ca;
  logic [31:0]     din_q;
  logic            we_q, drop_q, hit, inv, wr, last, unused_addr;
  logic [WW-1:0]   way_q, hway, iway, lru_way, vway, acc_way, dw, age;
  logic [OW-1:0]   cnt_q, word;
  logic [SW-1:0]   set;
  logic [TW-1:0]   tag;
  assign unused_addr = ^addr[1:0];
  // Outside IDLE every lookup refers to the latched miss address.
  assign ca   = state_q == IDLE ? addr[31:2] : addr_q;
  assign word = ca[OW-1:0];
  assign set  = ca[OW +: SW];
  assign tag  = ca[OW+SW +: TW];
  always_comb begin
    hit  = 1'b0;
    hway = '0;
    inv  = 1'b0;
    iway = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[set][w] && tag_q[w][set] == tag) begin hit = 1'b1; hway = WW'(w); end
      if (!valid_q[set][w]) begin inv = 1'b1; iway = WW'(w); end
    end
  end
  assign vway      = inv ? iway : lru_way;
  assign acc_way   = state_q == DONE ? way_q : hway;
  assign rdy       = en && (state_q == IDLE ? hit : state_q == DONE && !drop_q);
  assign wr        = rdy && (state_q == IDLE ? r0w1 : we_q);
  assign dout      = rdy && !wr ? data_q[acc_way][set][word] : '0;
  assign last      = mem_ack && &cnt_q;
  assign mem_req   = state_q == WB || state_q == FILL;
  assign mem_we    = state_q == WB;
  assign mem_addr  = state_q == WB ? {tag_q[way_q][set], set, cnt_q, 2'b00}
                   : state_q == FILL ? {addr_q[29:OW], cnt_q, 2'b00} : '0;
  assign mem_wdata = mem_we ? data_q[way_q][set][cnt_q] : '0;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && en && !hit) state_d = dirty_q[set][vway] ? WB : FILL;
    if (state_q == WB && last) state_d = FILL;
    if (state_q == FILL && last) state_d = DONE;
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      drop_q  <= 1'b0;
      way_q   <= '0;
      cnt_q   <= '0;
      for (int s = 0; s < SETS; s++) begin valid_q[s] <= '0; dirty_q[s] <= '0; end
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d != IDLE) begin
        addr_q <= addr[31:2];
        din_q  <= din;
        we_q   <= r0w1;
        way_q  <= vway;
        drop_q <= 1'b0;
        cnt_q  <= '0;
        valid_q[set][vway] <= 1'b0;
      end
      if (mem_req && !en) drop_q <= 1'b1;
      if (mem_req && mem_ack) cnt_q <= cnt_q + OW'(1);
      if (state_q == WB && last) dirty_q[set][way_q] <= 1'b0;
      if (state_q == FILL && last) begin valid_q[set][way_q] <= 1'b1; dirty_q[set][way_q] <= 1'b0; end
      if (wr) dirty_q[set][acc_way] <= 1'b1;
    end
  always_ff @(posedge clk) begin
    if (state_q == FILL && mem_ack) data_q[way_q][set][cnt_q] <= mem_rdata;
    if (state_q == FILL && last) tag_q[way_q][set] <= tag;
    if (wr) data_q[acc_way][set][word] <= state_q == IDLE ? din : din_q;
  end
  data_cache_sa_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
    .clk       (clk),
    .rst       (rst),
    .touch_i   (rdy),
    .set_i     (set),
    .way_i     (acc_way),
    .dbg_set_i (dbg_set),
    .dbg_way_i (dw),
    .victim_o  (lru_way),
    .dbg_age_o (age)
  );
  assign dw = WAYS == 1 ? '0 : dbg_way;
  always_comb begin
    dbg_line = '0;
    for (int i = 0; i < WORDS; i++) dbg_line[32*i +: 32] = data_q[dw][dbg_set][i];
  end
  assign dbg_flags = {valid_q[dbg_set][dw], dirty_q[dbg_set][dw], age};
endmodule
